// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router input-side control.
package router_pkg;

  localparam int          NUM_PORTS    = 3;
  localparam logic [1:0]  ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    WAIT_TILL_EMPTY    = 3'd1,
    LOAD_FIRST_DATA    = 3'd2,
    LOAD_DATA          = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    LOAD_PARITY        = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } router_state_t;

  // Select one of the per-FIFO status bits; the invalid address selects nothing.
  function automatic logic port_sel(logic [NUM_PORTS-1:0] v, logic [1:0] idx);
    logic r;
    r = 1'b0;
    case (idx)
      2'd0:    r = v[0];
      2'd1:    r = v[1];
      2'd2:    r = v[2];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/router_ctrl_fsm_if.sv
// Control-side signal bundle between the router FSM and its neighbours.
interface router_ctrl_fsm_if #(
  parameter int ADDR_W = 2
);
  logic              pkt_valid;
  logic [ADDR_W-1:0] data_in;
  logic              fifo_full;
  logic              fifo_empty_0;
  logic              fifo_empty_1;
  logic              fifo_empty_2;
  logic              soft_reset_0;
  logic              soft_reset_1;
  logic              soft_reset_2;
  logic              parity_done;
  logic              low_pkt_valid;

  logic              detect_add;
  logic              lfd_state;
  logic              ld_state;
  logic              laf_state;
  logic              full_state;
  logic              write_enb_reg;
  logic              rst_int_reg;
  logic              busy;

  modport master (
    output pkt_valid, data_in, fifo_full,
    output fifo_empty_0, fifo_empty_1, fifo_empty_2,
    output soft_reset_0, soft_reset_1, soft_reset_2,
    output parity_done, low_pkt_valid,
    input  detect_add, lfd_state, ld_state, laf_state, full_state,
    input  write_enb_reg, rst_int_reg, busy
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full,
    input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
    input  soft_reset_0, soft_reset_1, soft_reset_2,
    input  parity_done, low_pkt_valid,
    output detect_add, lfd_state, ld_state, laf_state, full_state,
    output write_enb_reg, rst_int_reg, busy
  );
endinterface

// File: rtl/router_ctrl_fsm.sv
// Packet-level control FSM: header decode, drain wait, payload/full-stall, parity.
module router_ctrl_fsm
  import router_pkg::*;
#(
  parameter int ADDR_W = 2
) (
  input  logic                clock,
  input  logic                reset,
  router_ctrl_fsm_if.slave    bus
);

  router_state_t          state, nxt;
  logic [1:0]             addr_q;
  logic [1:0]             hdr_addr;
  logic [NUM_PORTS-1:0]   empty_vec, srst_vec;
  logic                   hdr_ok, hdr_empty, sel_empty, sel_srst;

  assign hdr_addr  = bus.data_in[1:0];
  assign empty_vec = {bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
  assign srst_vec  = {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};
  assign hdr_ok    = bus.pkt_valid && (hdr_addr != ADDR_INVALID);
  // Header decode looks at the live address; later states use the latched one.
  assign hdr_empty = port_sel(empty_vec, hdr_addr);
  assign sel_empty = port_sel(empty_vec, addr_q);
  assign sel_srst  = port_sel(srst_vec, addr_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= DECODE_ADDRESS;
      addr_q <= 2'd0;
    end else begin
      state <= nxt;
      if (state == DECODE_ADDRESS && hdr_ok) addr_q <= hdr_addr;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      DECODE_ADDRESS:
        if (hdr_ok) nxt = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      WAIT_TILL_EMPTY:
        if (sel_empty) nxt = LOAD_FIRST_DATA;
      LOAD_FIRST_DATA:
        nxt = LOAD_DATA;
      LOAD_DATA:
        if (bus.fifo_full)       nxt = FIFO_FULL_STATE;
        else if (!bus.pkt_valid) nxt = LOAD_PARITY;
      FIFO_FULL_STATE:
        if (!bus.fifo_full) nxt = LOAD_AFTER_FULL;
      LOAD_AFTER_FULL:
        if (bus.parity_done)        nxt = DECODE_ADDRESS;
        else if (bus.low_pkt_valid) nxt = LOAD_PARITY;
        else                        nxt = LOAD_DATA;
      LOAD_PARITY:
        nxt = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR:
        nxt = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      default:
        nxt = DECODE_ADDRESS;
    endcase
    // A timeout on the selected FIFO abandons the packet in flight.
    if (state != DECODE_ADDRESS && sel_srst) nxt = DECODE_ADDRESS;
  end

  always_comb begin
    bus.detect_add    = 1'b0;
    bus.lfd_state     = 1'b0;
    bus.ld_state      = 1'b0;
    bus.laf_state     = 1'b0;
    bus.full_state    = 1'b0;
    bus.write_enb_reg = 1'b0;
    bus.rst_int_reg   = 1'b0;
    bus.busy          = 1'b1;
    case (state)
      DECODE_ADDRESS:     begin bus.detect_add = 1'b1; bus.busy = 1'b0; end
      WAIT_TILL_EMPTY:    ;
      LOAD_FIRST_DATA:    bus.lfd_state = 1'b1;
      LOAD_DATA:          begin bus.ld_state = 1'b1; bus.write_enb_reg = 1'b1; bus.busy = 1'b0; end
      FIFO_FULL_STATE:    bus.full_state = 1'b1;
      LOAD_AFTER_FULL:    begin bus.laf_state = 1'b1; bus.write_enb_reg = 1'b1; end
      LOAD_PARITY:        bus.write_enb_reg = 1'b1;
      CHECK_PARITY_ERROR: bus.rst_int_reg = 1'b1;
      default:            ;
    endcase
  end

endmodule

// File: tb/tb_router_ctrl_fsm.sv
// Table-driven bench with an expected-output scoreboard for router_ctrl_fsm.
module tb_router_ctrl_fsm;
  import router_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  router_ctrl_fsm_if #(.ADDR_W(2)) bus ();

  router_ctrl_fsm #(.ADDR_W(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string         nm;
    bit            rst;
    bit            pv;
    bit [1:0]      d;
    bit            full;
    bit [2:0]      emp;
    bit [2:0]      srst;
    bit            pd;
    bit            lpv;
    router_state_t st;
  } vec_t;

  vec_t     tbl[$];
  bit [7:0] exp_q[$];
  string    nm_q[$];
  int       total = 0;
  int       bad   = 0;

  function automatic vec_t mk(string nm, bit rst, bit pv, bit [1:0] d, bit full,
                              bit [2:0] emp, bit [2:0] srst, bit pd, bit lpv,
                              router_state_t st);
    vec_t v;
    v.nm = nm; v.rst = rst; v.pv = pv; v.d = d; v.full = full;
    v.emp = emp; v.srst = srst; v.pd = pd; v.lpv = lpv; v.st = st;
    return v;
  endfunction

  // {detect_add, lfd, ld, laf, full, write_enb, rst_int, busy} per state
  function automatic bit [7:0] exp_out(router_state_t s);
    case (s)
      DECODE_ADDRESS:     return 8'b1000_0000;
      WAIT_TILL_EMPTY:    return 8'b0000_0001;
      LOAD_FIRST_DATA:    return 8'b0100_0001;
      LOAD_DATA:          return 8'b0010_0100;
      FIFO_FULL_STATE:    return 8'b0000_1001;
      LOAD_AFTER_FULL:    return 8'b0001_0101;
      LOAD_PARITY:        return 8'b0000_0101;
      default:            return 8'b0000_0011;
    endcase
  endfunction

  task automatic apply(input vec_t v);
    bit [7:0] act, exp;
    string    nm;
    reset             = v.rst;
    bus.pkt_valid     = v.pv;
    bus.data_in       = v.d;
    bus.fifo_full     = v.full;
    bus.fifo_empty_0  = v.emp[0];
    bus.fifo_empty_1  = v.emp[1];
    bus.fifo_empty_2  = v.emp[2];
    bus.soft_reset_0  = v.srst[0];
    bus.soft_reset_1  = v.srst[1];
    bus.soft_reset_2  = v.srst[2];
    bus.parity_done   = v.pd;
    bus.low_pkt_valid = v.lpv;
    exp_q.push_back(exp_out(v.st));
    nm_q.push_back(v.nm);
    @(posedge clock);
    #1;
    act = {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
           bus.full_state, bus.write_enb_reg, bus.rst_int_reg, bus.busy};
    exp = exp_q.pop_front();
    nm  = nm_q.pop_front();
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: outputs got %b want %b", nm, act, exp);
    end
  endtask

  int wen_cnt;

  initial begin
    reset = 1'b1;
    bus.pkt_valid = 1'b0; bus.data_in = 2'b00; bus.fifo_full = 1'b0;
    bus.fifo_empty_0 = 1'b1; bus.fifo_empty_1 = 1'b1; bus.fifo_empty_2 = 1'b1;
    bus.soft_reset_0 = 1'b0; bus.soft_reset_1 = 1'b0; bus.soft_reset_2 = 1'b0;
    bus.parity_done = 1'b0; bus.low_pkt_valid = 1'b0;

    //                nm           rst pv d      full emp     srst    pd lpv state
    tbl.push_back(mk("reset0",     1, 0, 2'b00, 0, 3'b111, 3'b000, 0, 0, DECODE_ADDRESS));
    tbl.push_back(mk("reset1",     1, 1, 2'b01, 0, 3'b111, 3'b000, 0, 0, DECODE_ADDRESS));
    tbl.push_back(mk("idle",       0, 0, 2'b01, 0, 3'b111, 3'b000, 0, 0, DECODE_ADDRESS));
    // clean packet to FIFO1
    tbl.push_back(mk("p1_hdr",     0, 1, 2'b01, 0, 3'b010, 3'b000, 0, 0, LOAD_FIRST_DATA));
    tbl.push_back(mk("p1_lfd",     0, 1, 2'b00, 0, 3'b010, 3'b000, 0, 0, LOAD_DATA));
    tbl.push_back(mk("p1_ld1",     0, 1, 2'b00, 0, 3'b010, 3'b000, 0, 0, LOAD_DATA));
    tbl.push_back(mk("p1_ld2",     0, 1, 2'b00, 0, 3'b010, 3'b000, 0, 0, LOAD_DATA));
    tbl.push_back(mk("p1_ld3",     0, 0, 2'b00, 0, 3'b010, 3'b000, 0, 0, LOAD_PARITY));
    tbl.push_back(mk("p1_lp",      0, 0, 2'b00, 0, 3'b010, 3'b000, 0, 0, CHECK_PARITY_ERROR));
    tbl.push_back(mk("p1_cpe",     0, 0, 2'b00, 0, 3'b010, 3'b000, 0, 0, DECODE_ADDRESS));
    // busy destination FIFO2, then full stall with low_pkt_valid
    tbl.push_back(mk("w2_hdr",     0, 1, 2'b10, 0, 3'b011, 3'b000, 0, 0, WAIT_TILL_EMPTY));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk("w2_wait",  0, 1, 2'b10, 0, 3'b011, 3'b000, 0, 0, WAIT_TILL_EMPTY));
    tbl.push_back(mk("w2_empty",   0, 1, 2'b10, 0, 3'b111, 3'b000, 0, 0, LOAD_FIRST_DATA));
    tbl.push_back(mk("w2_lfd",     0, 1, 2'b00, 0, 3'b111, 3'b000, 0, 0, LOAD_DATA));
    tbl.push_back(mk("fs_full1",   0, 1, 2'b00, 1, 3'b111, 3'b000, 0, 0, FIFO_FULL_STATE));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk("fs_hold",  0, 1, 2'b00, 1, 3'b111, 3'b000, 0, 0, FIFO_FULL_STATE));
    tbl.push_back(mk("fs_free",    0, 0, 2'b00, 0, 3'b111, 3'b000, 0, 1, LOAD_AFTER_FULL));
    tbl.push_back(mk("laf_lpv",    0, 0, 2'b00, 0, 3'b111, 3'b000, 0, 1, LOAD_PARITY));
    // CHECK_PARITY_ERROR with FIFO full goes back to stall
    tbl.push_back(mk("lp2",        0, 0, 2'b00, 1, 3'b111, 3'b000, 0, 0, CHECK_PARITY_ERROR));
    tbl.push_back(mk("cpe_full",   0, 0, 2'b00, 1, 3'b111, 3'b000, 0, 0, FIFO_FULL_STATE));
    tbl.push_back(mk("ffs_free",   0, 0, 2'b00, 0, 3'b111, 3'b000, 0, 0, LOAD_AFTER_FULL));
    tbl.push_back(mk("laf_both",   0, 0, 2'b00, 0, 3'b111, 3'b000, 1, 1, DECODE_ADDRESS));
    // invalid header dropped
    tbl.push_back(mk("inv_hdr",    0, 1, 2'b11, 0, 3'b111, 3'b000, 0, 0, DECODE_ADDRESS));
    tbl.push_back(mk("inv_hdr2",   0, 1, 2'b11, 0, 3'b111, 3'b000, 0, 0, DECODE_ADDRESS));
    // full and pkt_valid low together; LAF with neither flag returns to LD
    tbl.push_back(mk("p0_hdr",     0, 1, 2'b00, 0, 3'b111, 3'b000, 0, 0, LOAD_FIRST_DATA));
    tbl.push_back(mk("p0_lfd",     0, 1, 2'b00, 0, 3'b111, 3'b000, 0, 0, LOAD_DATA));
    tbl.push_back(mk("ld_both",    0, 0, 2'b00, 1, 3'b111, 3'b000, 0, 0, FIFO_FULL_STATE));
    tbl.push_back(mk("ffs_free2",  0, 1, 2'b00, 0, 3'b111, 3'b000, 0, 0, LOAD_AFTER_FULL));
    tbl.push_back(mk("laf_none",   0, 1, 2'b00, 0, 3'b111, 3'b000, 0, 0, LOAD_DATA));
    tbl.push_back(mk("ld_srst1",   0, 1, 2'b00, 0, 3'b111, 3'b010, 0, 0, LOAD_DATA));
    tbl.push_back(mk("ld_srst0",   0, 1, 2'b00, 0, 3'b111, 3'b001, 0, 0, DECODE_ADDRESS));

    foreach (tbl[i]) apply(tbl[i]);

    // Soft reset in WAIT_TILL_EMPTY: non-selected FIFO ignored, selected one aborts
    apply(mk("sr_hdr",   0, 1, 2'b00, 0, 3'b110, 3'b000, 0, 0, WAIT_TILL_EMPTY));
    apply(mk("sr_other", 0, 1, 2'b00, 0, 3'b110, 3'b100, 0, 0, WAIT_TILL_EMPTY));
    apply(mk("sr_sel",   0, 1, 2'b01, 0, 3'b110, 3'b001, 0, 0, DECODE_ADDRESS));
    apply(mk("sr_idle",  0, 0, 2'b00, 0, 3'b110, 3'b001, 0, 0, DECODE_ADDRESS));

    // Reset in the middle of payload
    apply(mk("mr_hdr",   0, 1, 2'b10, 0, 3'b111, 3'b000, 0, 0, LOAD_FIRST_DATA));
    apply(mk("mr_lfd",   0, 1, 2'b00, 0, 3'b111, 3'b000, 0, 0, LOAD_DATA));
    apply(mk("mr_ld",    0, 1, 2'b00, 0, 3'b111, 3'b000, 0, 0, LOAD_DATA));
    apply(mk("mr_rst",   1, 1, 2'b00, 0, 3'b111, 3'b000, 0, 0, DECODE_ADDRESS));

    // Write-enable count over a clean packet to FIFO1 (header + 3 bytes + parity)
    wen_cnt = 0;
    apply(mk("wc_hdr",   0, 1, 2'b01, 0, 3'b111, 3'b000, 0, 0, LOAD_FIRST_DATA));
    wen_cnt += int'(bus.write_enb_reg);
    apply(mk("wc_lfd",   0, 1, 2'b00, 0, 3'b111, 3'b000, 0, 0, LOAD_DATA));
    wen_cnt += int'(bus.write_enb_reg);
    apply(mk("wc_ld1",   0, 1, 2'b00, 0, 3'b111, 3'b000, 0, 0, LOAD_DATA));
    wen_cnt += int'(bus.write_enb_reg);
    apply(mk("wc_ld2",   0, 1, 2'b00, 0, 3'b111, 3'b000, 0, 0, LOAD_DATA));
    wen_cnt += int'(bus.write_enb_reg);
    apply(mk("wc_ld3",   0, 0, 2'b00, 0, 3'b111, 3'b000, 0, 0, LOAD_PARITY));
    wen_cnt += int'(bus.write_enb_reg);
    apply(mk("wc_lp",    0, 0, 2'b00, 0, 3'b111, 3'b000, 0, 0, CHECK_PARITY_ERROR));
    wen_cnt += int'(bus.write_enb_reg);
    apply(mk("wc_cpe",   0, 0, 2'b00, 0, 3'b111, 3'b000, 0, 0, DECODE_ADDRESS));
    wen_cnt += int'(bus.write_enb_reg);
    total++;
    if (wen_cnt != 4) begin
      bad++;
      $display("FAIL wen_count: got %0d want 4", wen_cnt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/router_ctrl_fsm.md
Name: router_ctrl_fsm

Overview:
- Packet-level control FSM for the 1x3 router input side.
- Sequences one packet at a time, in order: header decode, wait for the destination FIFO to drain, payload load, full-stall and resume, parity load, parity check.
- Drives the write-enable request, address-detect and phase strobes consumed by the synchroniser (write_enb_reg, detect_add), the register/parity block (lfd/ld/laf/full/rst_int strobes) and the upstream source (busy).

Parameters:
- ADDR_W, 2, width of header destination field (data_in[1:0]); value 2'b11 is an invalid address.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high; clears state on the next rising edge of clock
- pkt_valid  in  1  source asserts for header+payload bytes, deasserts on parity byte
- data_in  in  ADDR_W  destination field of current input byte (meaningful on header)
- fifo_full  in  1  full status of currently selected FIFO (from synchroniser)
- fifo_empty_0/1/2  in  1 each  empty status of FIFO 0/1/2
- soft_reset_0/1/2  in  1 each  read-timeout soft resets from synchroniser
- parity_done  in  1  register block has captured the parity byte
- low_pkt_valid  in  1  register block: pkt_valid fell while FIFO was full
- detect_add  out  1  header decode phase; synchroniser latches address
- lfd_state  out  1  load-first-data (header write) phase
- ld_state  out  1  payload load phase
- laf_state  out  1  load-after-full phase
- full_state  out  1  FIFO-full stall phase
- write_enb_reg  out  1  request write to selected FIFO
- rst_int_reg  out  1  parity check phase; register block compares parity
- busy  out  1  source must hold current byte

Behaviour:
- Reset: state=DECODE_ADDRESS; addr_q=0.
  - Post-reset outputs: detect_add=1, all other outputs 0.
- Outputs: Moore, decoded from state only, no extra latency.
  - detect_add=DECODE_ADDRESS
  - lfd_state=LOAD_FIRST_DATA
  - ld_state=LOAD_DATA
  - laf_state=LOAD_AFTER_FULL
  - full_state=FIFO_FULL_STATE
  - rst_int_reg=CHECK_PARITY_ERROR
  - write_enb_reg=LOAD_DATA|LOAD_PARITY|LOAD_AFTER_FULL
  - busy=1 in every state except DECODE_ADDRESS and LOAD_DATA
- addr_q: loaded with data_in when state=DECODE_ADDRESS && pkt_valid && data_in!=3. It selects the fifo_empty_X and soft_reset_X inputs used below.
- DECODE_ADDRESS:
  - pkt_valid && data_in!=3 && fifo_empty[data_in] -> LOAD_FIRST_DATA.
  - pkt_valid && data_in!=3 && !fifo_empty[data_in] -> WAIT_TILL_EMPTY.
  - data_in==3 or !pkt_valid -> stay. An invalid header is dropped with no write.
- WAIT_TILL_EMPTY: fifo_empty[addr_q] -> LOAD_FIRST_DATA; else stay. busy=1 holds the header.
- LOAD_FIRST_DATA -> LOAD_DATA unconditionally (one cycle).
- LOAD_DATA:
  - fifo_full -> FIFO_FULL_STATE (fifo_full has priority).
  - else !pkt_valid -> LOAD_PARITY.
  - else stay.
- FIFO_FULL_STATE: !fifo_full -> LOAD_AFTER_FULL; else stay.
- LOAD_AFTER_FULL:
  - parity_done -> DECODE_ADDRESS.
  - else low_pkt_valid -> LOAD_PARITY.
  - else -> LOAD_DATA.
- LOAD_PARITY -> CHECK_PARITY_ERROR unconditionally.
- CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
- Soft reset:
  - soft_reset[addr_q] forces DECODE_ADDRESS from any state except DECODE_ADDRESS.
  - Priority: reset > soft_reset > normal transitions.
  - soft_reset of a non-selected FIFO is ignored.
- Reset mid-packet: abandon the packet; next cycle state is DECODE_ADDRESS.
- Simultaneous events:
  - fifo_full and !pkt_valid together in LOAD_DATA -> FIFO_FULL_STATE.
  - parity_done and low_pkt_valid together in LOAD_AFTER_FULL -> DECODE_ADDRESS.
- Encoding: one-hot or binary, implementer's choice. Illegal or unreachable codes recover to DECODE_ADDRESS.

Decomposition:
- Shared package router_pkg:
  - state enum router_state_t (8 states);
  - ADDR_INVALID=2'b11;
  - NUM_PORTS=3.
- No sub-module; a single flat FSM block is natural.
- The 3:1 empty/soft_reset select is inline.

Test Plan:
- Reset: assert reset 2 cycles, release -> detect_add=1, busy=0, write_enb_reg=0.
- Clean packet to FIFO1:
  - Stimulus: fifo_empty_1=1, header data_in=01 with pkt_valid=1, then 3 payload bytes, pkt_valid falls.
  - Required state sequence: DECODE_ADDRESS -> LOAD_FIRST_DATA (busy=1) -> LOAD_DATA x3 -> LOAD_PARITY -> CHECK_PARITY_ERROR (rst_int_reg=1) -> DECODE_ADDRESS.
  - write_enb_reg high for 4 cycles total.
- Busy destination:
  - Stimulus: header 10 with fifo_empty_2=0 for 5 cycles, then fifo_empty_2=1.
  - Required: WAIT_TILL_EMPTY for 5 cycles with busy=1, then LOAD_FIRST_DATA.
- Full stall:
  - Stimulus: fifo_full=1 during LOAD_DATA for 4 cycles, then 0, with low_pkt_valid=1.
  - Required: full_state=1 x4, then laf_state=1 for 1 cycle, then LOAD_PARITY.
- Invalid address and soft reset:
  - Header data_in=11 -> remains DECODE_ADDRESS, write_enb_reg=0.
  - In WAIT_TILL_EMPTY for addr 0, pulse soft_reset_0 -> DECODE_ADDRESS next cycle.
  - soft_reset_2 pulse while addr_q=0 -> no effect.
- Reset mid-packet: assert reset while in LOAD_DATA -> next cycle detect_add=1, ld_state=0.
